// File: rtl/fp_mul_exp_pipe.sv
// fp_mul_exp_pipe: 2-stage exponent/sign/class front end for the FP multiplier.
// Optional macro FP_MUL_EXP_SUBNORM_EN keeps subnormals as normals (exp 1) and adds out_sub.
`default_nettype none

module fp_mul_exp_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] mul1,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] mul2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sign,
  output logic [EXP_WIDTH-1:0]          out_exp,
  output logic [EXP_WIDTH+1:0]          out_exp_raw,
  output logic                          out_ovf,
  output logic                          out_unf,
  output logic                          out_zero,
  output logic                          out_inf,
`ifdef FP_MUL_EXP_SUBNORM_EN
  output logic                          out_sub,
`endif
  output logic                          out_nan
);

  localparam int                 SW     = EXP_WIDTH + 2;
  localparam logic [SW-1:0]      BIAS   = SW'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic [SW-1:0]      EMAX_W = SW'((2 ** EXP_WIDTH) - 1);
  localparam logic [EXP_WIDTH-1:0] EMAX = {EXP_WIDTH{1'b1}};

  // Operand field decode
  logic [EXP_WIDTH-1:0]  w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [MANT_WIDTH-1:0] w_ma, w_mb;
  logic w_ma_nz, w_mb_nz;
  logic w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic [SW-1:0] w_sum;

  assign w_ea    = mul1[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
  assign w_eb    = mul2[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
  assign w_ma    = mul1[MANT_WIDTH-1:0];
  assign w_mb    = mul2[MANT_WIDTH-1:0];
  assign w_ma_nz = |w_ma;
  assign w_mb_nz = |w_mb;

  assign w_inf_a = (w_ea == EMAX) && !w_ma_nz;
  assign w_inf_b = (w_eb == EMAX) && !w_mb_nz;
  assign w_nan_a = (w_ea == EMAX) && w_ma_nz;
  assign w_nan_b = (w_eb == EMAX) && w_mb_nz;

`ifdef FP_MUL_EXP_SUBNORM_EN
  logic w_sub_a, w_sub_b;
  assign w_sub_a  = (w_ea == '0) && w_ma_nz;
  assign w_sub_b  = (w_eb == '0) && w_mb_nz;
  assign w_zero_a = (w_ea == '0) && !w_ma_nz;
  assign w_zero_b = (w_eb == '0) && !w_mb_nz;
  assign w_ea_eff = w_sub_a ? EXP_WIDTH'(1) : w_ea;
  assign w_eb_eff = w_sub_b ? EXP_WIDTH'(1) : w_eb;
`else
  // Subnormals flush to zero: any zero exponent classifies as zero.
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  assign w_ea_eff = w_ea;
  assign w_eb_eff = w_eb;
`endif

  assign w_sum = {2'b00, w_ea_eff} + {2'b00, w_eb_eff} - BIAS;

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic w_adv1, w_adv2;
  assign w_adv2   = !s2_valid_q || out_ready;
  assign w_adv1   = !s1_valid_q || w_adv2;
  assign in_ready = w_adv1;

  // Stage 1 registers
  logic          s1_sign_q;
  logic          s1_zero_a_q, s1_zero_b_q, s1_inf_a_q, s1_inf_b_q, s1_nan_a_q, s1_nan_b_q;
  logic [SW-1:0] s1_sum_q;
`ifdef FP_MUL_EXP_SUBNORM_EN
  logic          s1_sub_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
      s1_inf_a_q  <= 1'b0;
      s1_inf_b_q  <= 1'b0;
      s1_nan_a_q  <= 1'b0;
      s1_nan_b_q  <= 1'b0;
      s1_sum_q    <= '0;
`ifdef FP_MUL_EXP_SUBNORM_EN
      s1_sub_q    <= 1'b0;
`endif
    end else if (w_adv1) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= mul1[EXP_WIDTH+MANT_WIDTH] ^ mul2[EXP_WIDTH+MANT_WIDTH];
      s1_zero_a_q <= w_zero_a;
      s1_zero_b_q <= w_zero_b;
      s1_inf_a_q  <= w_inf_a;
      s1_inf_b_q  <= w_inf_b;
      s1_nan_a_q  <= w_nan_a;
      s1_nan_b_q  <= w_nan_b;
      s1_sum_q    <= w_sum;
`ifdef FP_MUL_EXP_SUBNORM_EN
      s1_sub_q    <= w_sub_a | w_sub_b;
`endif
    end
  end

  // Stage 2 classification: nan > inf > zero > normal
  logic w_nan, w_inf, w_zero, w_normal, w_ovf, w_unf;
  logic [EXP_WIDTH-1:0] w_exp;

  assign w_nan    = s1_nan_a_q | s1_nan_b_q | (s1_inf_a_q & s1_zero_b_q) | (s1_zero_a_q & s1_inf_b_q);
  assign w_inf    = (s1_inf_a_q | s1_inf_b_q) & !w_nan;
  assign w_zero   = (s1_zero_a_q | s1_zero_b_q) & !w_nan & !w_inf;
  assign w_normal = !(w_nan | w_inf | w_zero);
  // Sum is signed; top bit set means negative.
  assign w_ovf    = w_normal && !s1_sum_q[SW-1] && (s1_sum_q >= EMAX_W);
  assign w_unf    = w_normal && (s1_sum_q[SW-1] || (s1_sum_q == '0));

  always_comb begin
    w_exp = s1_sum_q[EXP_WIDTH-1:0];
    if (w_nan || w_inf)      w_exp = EMAX;
    else if (w_zero)         w_exp = '0;
    else if (w_ovf)          w_exp = EMAX;
    else if (w_unf)          w_exp = '0;
  end

  logic                 s2_sign_q, s2_ovf_q, s2_unf_q, s2_zero_q, s2_inf_q, s2_nan_q;
  logic [EXP_WIDTH-1:0] s2_exp_q;
  logic [SW-1:0]        s2_raw_q;
`ifdef FP_MUL_EXP_SUBNORM_EN
  logic                 s2_sub_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_raw_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_nan_q   <= 1'b0;
`ifdef FP_MUL_EXP_SUBNORM_EN
      s2_sub_q   <= 1'b0;
`endif
    end else if (w_adv2) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q & !w_nan;
      s2_exp_q   <= w_exp;
      s2_raw_q   <= s1_sum_q;
      s2_ovf_q   <= w_ovf;
      s2_unf_q   <= w_unf;
      s2_zero_q  <= w_zero;
      s2_inf_q   <= w_inf;
      s2_nan_q   <= w_nan;
`ifdef FP_MUL_EXP_SUBNORM_EN
      s2_sub_q   <= s1_sub_q;
`endif
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_sign    = s2_sign_q;
  assign out_exp     = s2_exp_q;
  assign out_exp_raw = s2_raw_q;
  assign out_ovf     = s2_ovf_q;
  assign out_unf     = s2_unf_q;
  assign out_zero    = s2_zero_q;
  assign out_inf     = s2_inf_q;
  assign out_nan     = s2_nan_q;
`ifdef FP_MUL_EXP_SUBNORM_EN
  assign out_sub     = s2_sub_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_exp_pipe.sv
// tb_fp_mul_exp_pipe: directed checks of fp_mul_exp_pipe (default 8/23 format).
`default_nettype none

module tb_fp_mul_exp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mul1 = '0;
  logic [31:0] mul2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [9:0]  out_exp_raw;
  logic        out_ovf, out_unf, out_zero, out_inf, out_nan;
`ifdef FP_MUL_EXP_SUBNORM_EN
  logic        out_sub;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ONE = 32'h3F800000;

  fp_mul_exp_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mul1        (mul1),
    .mul2        (mul2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_exp_raw (out_exp_raw),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_zero    (out_zero),
    .out_inf     (out_inf),
`ifdef FP_MUL_EXP_SUBNORM_EN
    .out_sub     (out_sub),
`endif
    .out_nan     (out_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One operation through an idle pipe with out_ready high; checks latency and every field.
  task automatic send_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [9:0] e_raw, input logic [7:0] e_exp, input logic e_sign,
                                input logic e_ovf, input logic e_unf, input logic e_zero,
                                input logic e_inf, input logic e_nan, input logic e_sub);
    @(negedge clk);
    mul1 = a; mul2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_raw"},   {22'd0, out_exp_raw}, {22'd0, e_raw});
    check({tag, "_exp"},   {24'd0, out_exp}, {24'd0, e_exp});
    check({tag, "_flags"}, {26'd0, out_sign, out_ovf, out_unf, out_zero, out_inf, out_nan},
                           {26'd0, e_sign, e_ovf, e_unf, e_zero, e_inf, e_nan});
`ifdef FP_MUL_EXP_SUBNORM_EN
    check({tag, "_sub"}, {31'd0, out_sub}, {31'd0, e_sub});
`else
    if (e_sub) check({tag, "_sub_unexpected"}, 32'd1, 32'd0);
`endif
    @(negedge clk);
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  int          sent, got;
  logic        stall_prev;
  logic [9:0]  held;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_raw",   {22'd0, out_exp_raw}, 32'd0);
    check("rst_exp",   {24'd0, out_exp}, 32'd0);
    check("rst_flags", {26'd0, out_sign, out_ovf, out_unf, out_zero, out_inf, out_nan}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    //               tag      a             b             raw       exp     s  ov un z  i  n  sub
    send_and_check("one_two", ONE,          32'h40000000, 10'd128,  8'd128, 0, 0, 0, 0, 0, 0, 0);
    send_and_check("ovf",     32'h71800000, 32'h71800000, 10'd327,  8'd255, 0, 1, 0, 0, 0, 0, 0);
    send_and_check("unf",     32'h0D800000, 32'h0D800000, 10'h3B7,  8'd0,   0, 0, 1, 0, 0, 0, 0);
    send_and_check("inf_x_0", 32'h7F800000, 32'h00000000, 10'd128,  8'd255, 0, 0, 0, 0, 0, 1, 0);
    send_and_check("ninf",    32'hFF800000, ONE,          10'd255,  8'd255, 1, 0, 0, 0, 1, 0, 0);
    send_and_check("neg_one", 32'hBF800000, 32'h40000000, 10'd128,  8'd128, 1, 0, 0, 0, 0, 0, 0);
    send_and_check("nan_op",  32'hFFC00000, 32'hBF800000, 10'd255,  8'd255, 0, 0, 0, 0, 0, 1, 0);
    send_and_check("exact_e", 32'h7F000000, 32'h40000000, 10'd255,  8'd255, 0, 1, 0, 0, 0, 0, 0);
    send_and_check("zero_e",  32'h00800000, 32'h3F000000, 10'd0,    8'd0,   0, 0, 1, 0, 0, 0, 0);
`ifdef FP_MUL_EXP_SUBNORM_EN
    send_and_check("subn",    32'h00000001, ONE,          10'd1,    8'd1,   0, 0, 0, 0, 0, 0, 1);
`else
    send_and_check("subn",    32'h80000001, ONE,          10'd0,    8'd0,   1, 0, 0, 1, 0, 0, 0);
`endif

    // Streaming with a 3-cycle downstream stall
    sent = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 4);
      mul1      = {1'b0, 8'(10 * (sent + 1)), 23'd0};
      mul2      = ONE;
      #1;
      if (stall_prev) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_raw", {22'd0, out_exp_raw}, {22'd0, held});
      end
      if (cyc >= 3 && cyc <= 5) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      stall_prev = out_valid && !out_ready;
      held       = out_exp_raw;
      if (out_valid && out_ready) begin
        check("stream_raw", {22'd0, out_exp_raw}, 32'(10 * (got + 1)));
        check("stream_exp", {24'd0, out_exp}, 32'(10 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 32'(sent), 32'd4);
    check("stream_got",  32'(got), 32'd4);

    // Reset while two operations are in flight
    @(negedge clk);
    in_valid = 1'b1; mul1 = 32'h41000000; mul2 = ONE;
    @(negedge clk);
    mul1 = 32'h41800000;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1 check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    send_and_check("after_rst", ONE, 32'h40000000, 10'd128, 8'd128, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
